rr_arb8_enc: RTL and testbench

//   8-requester round-robin arbiter. Emits the winner as a 3-bit binary index plus
//   an enable (gnt_idx, gnt_en), so it feeds a 3x8 decoder stage directly
//   (gnt_en -> en, gnt_idx -> i). Grants are held until the owner signals completion
//   or withdraws its request. Fairness comes from a rotating priority pointer.

---
 rtl/rr_arb8_enc.sv | 121 ++++++++++++
 tb/tb_rr_arb8_enc.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/rr_arb8_enc.sv
// 8-requester round-robin arbiter with binary-encoded grant (gnt_idx + gnt_en).
// Optional forced release after TIMEOUT grant cycles when ARB_TIMEOUT_EN is defined.
module rr_arb8_enc #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic       gnt_en,
  output logic [2:0] gnt_idx,
  output logic       busy,
  output logic       tout
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range_bad
    $error("rr_arb8_enc: TIMEOUT must be in 1..255");
  end

  logic [0:0] state_reg;
  logic [2:0] ptr_reg;
  logic [2:0] gnt_idx_reg;
  logic       tout_reg;

  // Requests rotated so that bit 0 is the requester at the priority pointer.
  logic [7:0] rot_req;

  for (genvar gi = 0; gi < 8; gi++) begin : g_rot
    logic [2:0] src;
    assign src         = ptr_reg + 3'(gi);
    assign rot_req[gi] = req[src];
  end

  logic [2:0] win_offs;
  logic [2:0] winner;
  logic       any_req;

  always_comb begin
    win_offs = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rot_req[i]) win_offs = 3'(i);
    end
  end

  assign any_req = |req;
  assign winner  = ptr_reg + win_offs;

  logic owner_req;
  logic release_std;
  logic expire;

  assign owner_req   = req[gnt_idx_reg];
  assign release_std = done | ~owner_req;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_reg;

  assign expire = (cnt_reg == TO_LAST);

  // Counts cycles spent in GRANT; saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= 8'd0;
    end else if (state_reg == GRANT) begin
      if (cnt_reg != 8'hFF) cnt_reg <= cnt_reg + 8'd1;
    end else begin
      cnt_reg <= 8'd0;
    end
  end
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      ptr_reg     <= 3'd0;
      gnt_idx_reg <= 3'd0;
      tout_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          tout_reg <= 1'b0;
          if (any_req) begin
            state_reg   <= GRANT;
            gnt_idx_reg <= winner;
          end
        end
        GRANT: begin
          if (release_std || expire) begin
            state_reg <= IDLE;
            ptr_reg   <= gnt_idx_reg + 3'd1;
            // A coinciding done/withdrawal makes it an ordinary release.
            tout_reg  <= expire & ~release_std;
          end else begin
            tout_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          tout_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_en  = (state_reg == GRANT);
  assign busy    = gnt_en;
  assign gnt_idx = gnt_idx_reg;
`ifdef ARB_TIMEOUT_EN
  assign tout    = tout_reg;
`else
  assign tout    = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arb8_enc.sv
// Bench for rr_arb8_enc: directed scenarios then random traffic, checked against
// a behavioural arbiter model (honours ARB_TIMEOUT_EN with TIMEOUT=4).
module tb_rr_arb8_enc;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic       gnt_en;
  logic [2:0] gnt_idx;
  logic       busy;
  logic       tout;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  bit m_busy = 0;
  int m_idx  = 0;
  int m_ptr  = 0;
  int m_held = 0;
  bit m_tout = 0;

`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  rr_arb8_enc #(.TIMEOUT(TO)) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .done   (done),
    .gnt_en (gnt_en),
    .gnt_idx(gnt_idx),
    .busy   (busy),
    .tout   (tout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Advance the model by one clock edge given the inputs sampled at that edge.
  task automatic model_edge(input logic [7:0] r, input logic d, input logic rs);
    bit rel, timed;
    if (rs) begin
      m_busy = 0; m_idx = 0; m_ptr = 0; m_held = 0; m_tout = 0;
    end else if (!m_busy) begin
      m_tout = 0;
      if (r != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          if (r[(m_ptr + k) % 8]) begin
            m_idx = (m_ptr + k) % 8;
            break;
          end
        end
        m_busy = 1;
        m_held = 1;
      end
    end else begin
      rel   = d || !r[m_idx];
      timed = TO_EN && (m_held >= TO);
      if (rel || timed) begin
        m_busy = 0;
        m_ptr  = (m_idx + 1) % 8;
        m_tout = timed && !rel;
      end else begin
        m_held++;
        m_tout = 0;
      end
    end
  endtask

  task automatic step(input logic [7:0] r, input logic d, input logic rs);
    req  = r;
    done = d;
    rst  = rs;
    model_edge(r, d, rs);
    @(posedge clk);
    #1;
    chk("gnt_en",  {7'd0, gnt_en}, {7'd0, m_busy});
    chk("busy",    {7'd0, busy},   {7'd0, m_busy});
    chk("gnt_idx", {5'd0, gnt_idx}, 8'(m_idx));
    chk("tout",    {7'd0, tout},   {7'd0, m_tout});
  endtask

  initial begin
    int run, tcount;
    bit in_run;
    logic [7:0] r;

    // 1. Reset with all requests pending
    step(8'hFF, 1'b0, 1'b1);
    chk("rst_gnt_en", {7'd0, gnt_en}, 8'd0);
    step(8'hFF, 1'b0, 1'b1);
    chk("rst_gnt_idx", {5'd0, gnt_idx}, 8'd0);
    step(8'hFF, 1'b0, 1'b0);
    chk("first_grant_idx", {5'd0, gnt_idx}, 8'd0);
    chk("first_grant_en", {7'd0, gnt_en}, 8'd1);
    step(8'h00, 1'b1, 1'b0);

    // 2. Single request
    step(8'h04, 1'b0, 1'b0);
    chk("single_idx", {5'd0, gnt_idx}, 8'd2);
    step(8'h04, 1'b0, 1'b0);
    step(8'h04, 1'b1, 1'b0);
    chk("single_release", {7'd0, gnt_en}, 8'd0);
    step(8'h00, 1'b0, 1'b0);

    // 3. Rotation from ptr=0
    step(8'h00, 1'b0, 1'b1);
    for (int g = 0; g < 9; g++) begin
      step(8'hFF, 1'b0, 1'b0);
      chk("rot_idx", {5'd0, gnt_idx}, 8'(g % 8));
      step(8'hFF, 1'b1, 1'b0);
      chk("rot_gap", {7'd0, gnt_en}, 8'd0);
    end

    // 4. Wrap: after grant to 7, req 0x81 -> 0 then 7
    step(8'h00, 1'b0, 1'b1);
    step(8'h80, 1'b0, 1'b0);
    chk("wrap_g7", {5'd0, gnt_idx}, 8'd7);
    step(8'h80, 1'b1, 1'b0);
    step(8'h81, 1'b0, 1'b0);
    chk("wrap_g0", {5'd0, gnt_idx}, 8'd0);
    step(8'h81, 1'b1, 1'b0);
    step(8'h81, 1'b0, 1'b0);
    chk("wrap_g7b", {5'd0, gnt_idx}, 8'd7);
    step(8'h00, 1'b0, 1'b0);

    // 5. Withdrawal then reset mid-grant
    step(8'h00, 1'b0, 1'b1);
    step(8'h08, 1'b0, 1'b0);
    chk("wd_idx", {5'd0, gnt_idx}, 8'd3);
    step(8'h00, 1'b0, 1'b0);
    chk("wd_drop", {7'd0, gnt_en}, 8'd0);
    step(8'hFF, 1'b0, 1'b0);
    chk("wd_ptr4", {5'd0, gnt_idx}, 8'd4);
    step(8'hFF, 1'b0, 1'b1);
    chk("rst_mid", {7'd0, gnt_en}, 8'd0);

    // 6. Timeout behaviour with a lone persistent requester
    step(8'h00, 1'b0, 1'b1);
    run = 0; tcount = 0; in_run = 1'b1;
    for (int c = 0; c < 25; c++) begin
      step(8'h01, 1'b0, 1'b0);
      if (tout) tcount++;
      if (in_run) begin
        if (gnt_en) run++;
        else in_run = 1'b0;
      end
    end
`ifdef ARB_TIMEOUT_EN
    chk("to_run_len", 8'(run), 8'(TO));
    chk("to_pulses_nonzero", {7'd0, (tcount > 0)}, 8'd1);
`else
    chk("hold_run_len", 8'(run), 8'd25);
    chk("no_tout", 8'(tcount), 8'd0);
`endif
    step(8'h00, 1'b0, 1'b0);

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      r = 8'($urandom) & 8'($urandom);
      step(r, ($urandom % 4) == 0, ($urandom % 64) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
